// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencing logic.
// Also holds the MIPS MD-class encodings used by the D/E controllers.
package md_pkg;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    localparam logic [5:0] MD_OP_SPECIAL = 6'h00;
    localparam logic [5:0] MD_FN_MFHI    = 6'h10;
    localparam logic [5:0] MD_FN_MTHI    = 6'h11;
    localparam logic [5:0] MD_FN_MFLO    = 6'h12;
    localparam logic [5:0] MD_FN_MTLO    = 6'h13;
    localparam logic [5:0] MD_FN_MULT    = 6'h18;
    localparam logic [5:0] MD_FN_MULTU   = 6'h19;
    localparam logic [5:0] MD_FN_DIV     = 6'h1A;
    localparam logic [5:0] MD_FN_DIVU    = 6'h1B;

    // mult/multu/div/divu: instructions that start the unit
    function automatic logic md_is_start(input logic [5:0] op, input logic [5:0] fn);
        return (op == MD_OP_SPECIAL) &&
               ((fn == MD_FN_MULT) || (fn == MD_FN_MULTU) ||
                (fn == MD_FN_DIV)  || (fn == MD_FN_DIVU));
    endfunction

    function automatic logic md_is_div(input logic [5:0] op, input logic [5:0] fn);
        return (op == MD_OP_SPECIAL) && ((fn == MD_FN_DIV) || (fn == MD_FN_DIVU));
    endfunction

    // Any instruction touching HI/LO: must wait for an in-flight operation
    function automatic logic md_is_use(input logic [5:0] op, input logic [5:0] fn);
        return md_is_start(op, fn) ||
               ((op == MD_OP_SPECIAL) &&
                ((fn == MD_FN_MFHI) || (fn == MD_FN_MTHI) ||
                 (fn == MD_FN_MFLO) || (fn == MD_FN_MTLO)));
    endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Down-counter timing one MD operation: load, decrement, clear, last-cycle flag.
module md_cycle_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] remain_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clear wins over load; decrement saturates at zero so the count never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign remain_o = cnt_q;
    assign last_o   = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/md_scheduler.sv
// HI/LO multiply/divide sequencer: times the op, pulses Commit, drives StallD.
// Optional E-stage flush input CancelE when MD_SCHEDULER_CANCEL_EN is defined.
module md_scheduler
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             StartE,
    input  logic             IsDivE,
    input  logic             MdUseD,
`ifdef MD_SCHEDULER_CANCEL_EN
    input  logic             CancelE,
`endif
    output logic             LoadOps,
    output logic             Busy,
    output logic             Commit,
    output logic             StallD,
    output logic [CNT_W-1:0] Remain,
    output logic             ErrOverrun
);

    md_state_e        state_q, state_d;
    logic             commit_q, commit_d;
    logic             err_q, err_d;
    logic             run;
    logic             cancel;
    logic             start_ok;
    logic             last;
    logic [CNT_W-1:0] n_sel;

`ifdef MD_SCHEDULER_CANCEL_EN
    assign cancel = CancelE;
`else
    assign cancel = 1'b0;
`endif

    assign run      = (state_q == MD_RUN);
    assign start_ok = StartE & ~run & ~cancel;
    assign n_sel    = IsDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .load_i     (start_ok),
        .load_val_i (n_sel),
        .dec_i      (run),
        .clr_i      (run & (last | cancel)),
        .remain_o   (Remain),
        .last_o     (last)
    );

    // Commit is registered: raised on the edge that brings Remain to 1
    always_comb begin
        state_d  = state_q;
        commit_d = 1'b0;
        err_d    = err_q | (StartE & run);
        if (run) begin
            if (last || cancel) begin
                state_d = MD_IDLE;
            end else if (Remain == CNT_W'(2)) begin
                commit_d = 1'b1;
            end
        end else if (start_ok) begin
            state_d  = MD_RUN;
            commit_d = (n_sel == CNT_W'(1));
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= MD_IDLE;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    assign LoadOps    = start_ok;
    assign Busy       = run;
    assign Commit     = commit_q & ~cancel;
    assign StallD     = MdUseD & (StartE | run);
    assign ErrOverrun = err_q;

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Sequencing controller for the multi-cycle multiply/divide (HI/LO) datapath added alongside the E stage.
- Accepts a start from E, then times the operation: a fixed MULT_CYCLES or DIV_CYCLES latency.
- Pulses the HI/LO commit enable at the end of the operation.
- Drives the decode-stage stall: a HI/LO-using instruction in D waits while the unit is starting or busy.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- StartE  input  1  E-stage instr is mult/multu/div/divu; valid for one cycle.
- IsDivE  input  1  qualifies StartE: 1 = div/divu, 0 = mult/multu.
- MdUseD  input  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- LoadOps  output  1  combinational; load the operand registers of the MD datapath this cycle.
- Busy  output  1  registered; operation in flight.
- Commit  output  1  registered; one-cycle HI/LO write enable.
- StallD  output  1  combinational; freeze PC/D, bubble E.
- Remain  output  CNT_W  cycles remaining, including the current one (0 when idle).
- ErrOverrun  output  1  sticky; StartE arrived while Busy.

Behaviour:
- States: IDLE, RUN.
- Reset (Reset=0, async): state=IDLE, Remain=0, Busy=0, Commit=0, ErrOverrun=0. Takes effect immediately, including mid-operation. An aborted operation never commits.
- LoadOps = StartE & (state==IDLE).
- IDLE, StartE=1 at edge k:
  - Next state RUN.
  - Remain loads N, where N = DIV_CYCLES if IsDivE else MULT_CYCLES; the op type is latched.
  - Busy=1 from k+1 through k+N inclusive (exactly N cycles).
- RUN:
  - Remain decrements each edge.
  - In the cycle where Remain==1: Commit=1 (registered, so it is asserted during that cycle), and next state is IDLE with Remain=0.
  - Commit is high for exactly one cycle per operation, coincident with the last Busy cycle.
- Latency: start at cycle k -> Commit visible in cycle k+N -> Busy low in cycle k+N+1.
- N=1: Busy and Commit both high in cycle k+1 only.
- StallD = MdUseD & (StartE | Busy).
  - StallD falls in the cycle after the last Busy cycle, so mfhi/mflo read the committed HI/LO.
  - A new start is accepted in the first IDLE cycle; back-to-back ops are separated by at least one idle cycle.
- StartE while RUN:
  - Cannot occur with a correct StallD; if it does, it is ignored, the counter is unaffected, and ErrOverrun sets until reset.
- StartE with Commit in the same cycle: still RUN, so it is ignored and flagged.
- MdUseD alone (no StartE, not Busy): no stall.
- Remain never wraps: decrement happens only in RUN with Remain≥1.

Optional Feature:
- Macro MD_SCHEDULER_CANCEL_EN.
- With the macro: extra port CancelE (input, 1), an exception flush from the E stage.
  - In RUN: next state IDLE, Remain=0, no Commit (Commit is forced 0 even if Remain==1 that cycle).
  - In IDLE: CancelE=1 blocks StartE; LoadOps=0 and no state change.
- Without the macro: no CancelE port; an operation always runs to Commit unless reset.

Decomposition:
- Package md_pkg holds:
  - the state enum (IDLE, RUN);
  - default cycle constants MD_MULT_CYCLES=5 and MD_DIV_CYCLES=10;
  - MIPS opcode/funct constants for the MD class, shared with the D/E controllers that produce MdUseD/StartE/IsDivE.
- Sub-module md_cycle_counter: load value, decrement enable, clear, and a last-cycle flag (Remain==1). Remain is taken from it.

Test Plan:
- Reset=0 for 2 cycles, then release -> all outputs 0 and Remain=0; no Commit for 20 idle cycles.
- StartE=1, IsDivE=0 at cycle 3 -> LoadOps=1 in cycle 3; Busy=1 in cycles 4..8; Remain 5,4,3,2,1; Commit=1 only in cycle 8; Busy=0 in cycle 9.
- Div started at cycle 3, MdUseD=1 (mflo) held from cycle 3 -> StallD=1 in cycles 3..13, StallD=0 in cycle 14; Commit in cycle 13.
- Mult start, then StartE forced high in cycle 6 (while Busy) -> ignored, Commit still in cycle 8, ErrOverrun=1 and held until reset.
- Div started, Reset pulsed low for half a cycle at cycle 7 -> Busy, Remain and state clear asynchronously; no Commit ever; a new mult started at cycle 10 commits at cycle 15.
- With MD_SCHEDULER_CANCEL_EN: div start at cycle 3, CancelE=1 in cycle 6 -> Busy=0 from cycle 7, no Commit; CancelE=1 together with StartE=1 in IDLE -> LoadOps=0 and no start.
